// File: rtl/multdiv_issue_ctrl.sv
// Execute-stage sequencer for the iterative multdiv unit: issues one MULT/DIV, stalls until the
// result is ready, then emits a one-cycle writeback packet. Optional abort via MULTDIV_TIMEOUT_EN.
module multdiv_issue_ctrl #(
    parameter logic [4:0] STATUS_REG = 5'd30
`ifdef MULTDIV_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 48
`endif
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        issue_valid_i,
    input  logic        issue_is_div_i,
    input  logic [31:0] issue_op_a_i,
    input  logic [31:0] issue_op_b_i,
    input  logic [4:0]  issue_rd_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic [31:0] md_operand_a_o,
    output logic [31:0] md_operand_b_o,
    output logic        md_ctrl_mult_o,
    output logic        md_ctrl_div_o,
    input  logic [31:0] md_result_i,
    input  logic        md_exception_i,
    input  logic        md_result_rdy_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        wb_exception_o
);

    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_e;

    state_e      state_q, state_d;
    logic [31:0] op_a_q, op_b_q;
    logic [4:0]  rd_q;
    logic        is_div_q;
    logic        first_busy_q;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_exc_q, wb_exc_d;
    logic        rdy_ok;
    logic        timeout_hit;
    logic        accept;
    logic        finish;

    // The multdiv may raise a stale rdy in the cycle right after the start pulse.
    assign rdy_ok = md_result_rdy_i && !first_busy_q;

`ifdef MULTDIV_TIMEOUT_EN
    logic [5:0] busy_cnt_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            busy_cnt_q <= '0;
        end else if (state_q == START) begin
            busy_cnt_q <= '0;
        end else if (state_q == BUSY) begin
            busy_cnt_q <= busy_cnt_q + 6'd1;
        end
    end

    assign timeout_hit = (state_q == BUSY) && (busy_cnt_q == 6'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (issue_valid_i && !flush_i) state_d = START;
            START: state_d = flush_i ? IDLE : BUSY;
            BUSY: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (rdy_ok || timeout_hit) begin
                    state_d = DONE;
                end
            end
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_o        = 1'b0;
        md_ctrl_mult_o = 1'b0;
        md_ctrl_div_o  = 1'b0;
        wb_valid_o     = 1'b0;
        case (state_q)
            IDLE:  stall_o = issue_valid_i;
            START: begin
                stall_o        = 1'b1;
                md_ctrl_mult_o = !is_div_q && !reset_i;
                md_ctrl_div_o  = is_div_q && !reset_i;
            end
            BUSY:  stall_o = 1'b1;
            DONE:  wb_valid_o = !flush_i && !reset_i;
            default: stall_o = 1'b0;
        endcase
    end

    assign accept = (state_q == IDLE) && (state_d == START);
    assign finish = (state_q == BUSY) && (state_d == DONE);

    // A timeout is reported exactly like a multdiv exception.
    always_comb begin
        wb_exc_d  = !rdy_ok || md_exception_i;
        wb_rd_d   = rd_q;
        wb_data_d = md_result_i;
        if (wb_exc_d) begin
            wb_rd_d   = STATUS_REG;
            wb_data_d = is_div_q ? 32'd5 : 32'd4;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            op_a_q       <= '0;
            op_b_q       <= '0;
            rd_q         <= '0;
            is_div_q     <= 1'b0;
            first_busy_q <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            wb_exc_q     <= 1'b0;
        end else begin
            first_busy_q <= (state_q == START);
            if (accept) begin
                op_a_q   <= issue_op_a_i;
                op_b_q   <= issue_op_b_i;
                rd_q     <= issue_rd_i;
                is_div_q <= issue_is_div_i;
            end
            if (finish) begin
                wb_rd_q   <= wb_rd_d;
                wb_data_q <= wb_data_d;
                wb_exc_q  <= wb_exc_d;
            end
        end
    end

    assign md_operand_a_o = op_a_q;
    assign md_operand_b_o = op_b_q;
    assign wb_rd_o        = wb_rd_q;
    assign wb_data_o      = wb_data_q;
    assign wb_exception_o = wb_exc_q;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Randomized bench for multdiv_issue_ctrl; the bench plays the multdiv unit and predicts each
// transaction's pulses, stall window and writeback from cycle offsets relative to acceptance.
module tb_multdiv_issue_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic        issue_is_div;
    logic [31:0] issue_op_a;
    logic [31:0] issue_op_b;
    logic [4:0]  issue_rd;
    logic        flush;
    logic        stall;
    logic [31:0] md_operand_a;
    logic [31:0] md_operand_b;
    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_result_rdy;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exception;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] prev_a = '0;
    logic [31:0] prev_b = '0;

    always #5 clock = ~clock;

    multdiv_issue_ctrl dut (
        .clock_i        (clock),
        .reset_i        (reset),
        .issue_valid_i  (issue_valid),
        .issue_is_div_i (issue_is_div),
        .issue_op_a_i   (issue_op_a),
        .issue_op_b_i   (issue_op_b),
        .issue_rd_i     (issue_rd),
        .flush_i        (flush),
        .stall_o        (stall),
        .md_operand_a_o (md_operand_a),
        .md_operand_b_o (md_operand_b),
        .md_ctrl_mult_o (md_ctrl_mult),
        .md_ctrl_div_o  (md_ctrl_div),
        .md_result_i    (md_result),
        .md_exception_i (md_exception),
        .md_result_rdy_i(md_result_rdy),
        .wb_valid_o     (wb_valid),
        .wb_rd_o        (wb_rd),
        .wb_data_o      (wb_data),
        .wb_exception_o (wb_exception)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic is_div, input logic [31:0] a,
                                               input logic [31:0] b);
        if (!is_div) return a * b;
        if (b == 32'd0) return 32'd0;
        return 32'($signed(a) / $signed(b));
    endfunction

    task automatic drive_idle();
        issue_valid   = 1'b0;
        flush         = 1'b0;
        md_result_rdy = 1'b0;
        md_exception  = 1'($urandom_range(0, 1));
        md_result     = $urandom;
    endtask

    task automatic idle_cycle();
        @(negedge clock);
        drive_idle();
        #1;
        check("idle_stall", stall, 1'b0);
        check("idle_wb_valid", wb_valid, 1'b0);
        check("idle_mult", md_ctrl_mult, 1'b0);
        check("idle_div", md_ctrl_div, 1'b0);
        check("idle_opa", md_operand_a, prev_a);
        check("idle_opb", md_operand_b, prev_b);
    endtask

    // idx 0 is the first cycle after acceptance; rdy_at >= 2, flush_at < 0 means no flush.
    task automatic run_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int rdy_at, input logic exc_in,
                          input int flush_at, input logic spur);
        logic [31:0] res;
        logic        exc;
        logic        exc_exp;
        logic        flushed;
        logic        stall_exp;
        logic        wb_exp;
        int          d;
        int          end_idx;
        res     = ref_result(is_div, a, b);
        exc     = exc_in || (is_div && b == 32'd0);
        exc_exp = exc;
        d       = rdy_at + 1;
`ifdef MULTDIV_TIMEOUT_EN
        if (rdy_at > 48) begin
            d       = 49;
            exc_exp = 1'b1;
        end
`endif
        flushed = (flush_at >= 0) && (flush_at <= d);
        end_idx = flushed ? flush_at : d;

        @(negedge clock);
        drive_idle();
        issue_valid  = 1'b1;
        issue_is_div = is_div;
        issue_op_a   = a;
        issue_op_b   = b;
        issue_rd     = rd;
        #1;
        check("issue_stall", stall, 1'b1);
        check("issue_opa_held", md_operand_a, prev_a);
        check("issue_opb_held", md_operand_b, prev_b);
        check("issue_wb_valid", wb_valid, 1'b0);

        for (int idx = 0; idx <= end_idx; idx++) begin
            @(negedge clock);
            issue_valid   = !(flushed && idx >= flush_at);
            issue_op_a    = $urandom;
            issue_op_b    = $urandom;
            issue_rd      = 5'($urandom);
            issue_is_div  = 1'($urandom_range(0, 1));
            flush         = (idx == flush_at);
            md_result_rdy = (idx == rdy_at) || (idx == 1 && spur);
            md_result     = (idx == rdy_at) ? res : $urandom;
            md_exception  = (idx == rdy_at) ? exc : 1'($urandom_range(0, 1));
            #1;
            if (flushed && flush_at < d) stall_exp = (idx <= flush_at);
            else stall_exp = (idx < d);
            wb_exp = !flushed && (idx == d);
            check("stall", stall, stall_exp);
            check("wb_valid", wb_valid, wb_exp);
            check("ctrl_mult", md_ctrl_mult, idx == 0 && !is_div);
            check("ctrl_div", md_ctrl_div, idx == 0 && is_div);
            check("opa_stable", md_operand_a, a);
            check("opb_stable", md_operand_b, b);
            if (wb_exp) begin
                check("wb_rd", wb_rd, exc_exp ? 5'd30 : rd);
                check("wb_data", wb_data, exc_exp ? (is_div ? 32'd5 : 32'd4) : res);
                check("wb_exception", wb_exception, exc_exp);
            end
        end
        prev_a = a;
        prev_b = b;
    endtask

    task automatic reset_mid_op();
        @(negedge clock);
        drive_idle();
        issue_valid  = 1'b1;
        issue_is_div = 1'b0;
        issue_op_a   = 32'd11;
        issue_op_b   = 32'd13;
        issue_rd     = 5'd4;
        @(negedge clock);
        issue_valid = 1'b0;
        reset       = 1'b1;
        #1;
        check("rst_mult_gated", md_ctrl_mult, 1'b0);
        check("rst_wb_valid", wb_valid, 1'b0);
        @(negedge clock);
        reset         = 1'b0;
        md_result_rdy = 1'b1;
        #1;
        check("rst_stall", stall, 1'b0);
        check("rst_wb_valid_after", wb_valid, 1'b0);
        check("rst_opa", md_operand_a, 32'd0);
        prev_a = '0;
        prev_b = '0;
        idle_cycle();
    endtask

    initial begin
        logic        is_div;
        logic [31:0] a;
        logic [31:0] b;
        int          rdy_at;
        int          flush_at;

        reset        = 1'b1;
        issue_is_div = 1'b0;
        issue_op_a   = '0;
        issue_op_b   = '0;
        issue_rd     = '0;
        drive_idle();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("reset_stall", stall, 1'b0);
        check("reset_opa", md_operand_a, 32'd0);
        check("reset_opb", md_operand_b, 32'd0);
        check("reset_mult", md_ctrl_mult, 1'b0);
        check("reset_div", md_ctrl_div, 1'b0);
        check("reset_wb_valid", wb_valid, 1'b0);
        check("reset_wb_rd", wb_rd, 5'd0);
        check("reset_wb_data", wb_data, 32'd0);
        check("reset_wb_exc", wb_exception, 1'b0);

        run_op(1'b0, 32'd7, 32'd6, 5'd3, 16, 1'b0, -1, 1'b0);
        idle_cycle();
        run_op(1'b1, 32'hFFFF_FFEC, 32'd3, 5'd5, 10, 1'b0, -1, 1'b1);
        run_op(1'b1, 32'd9, 32'd0, 5'd7, 5, 1'b1, -1, 1'b0);
        run_op(1'b0, 32'd123, 32'd456, 5'd9, 12, 1'b0, 6, 1'b0);
        idle_cycle();
        run_op(1'b0, 32'h1234_5678, 32'd3, 5'd1, 3, 1'b0, -1, 1'b0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 5'd2, 2, 1'b0, -1, 1'b1);
        run_op(1'b1, 32'd100, 32'd7, 5'd6, 5, 1'b0, 0, 1'b0);
        run_op(1'b1, 32'd100, 32'd9, 5'd8, 4, 1'b0, 4, 1'b0);
        run_op(1'b0, 32'd5, 32'd5, 5'd10, 4, 1'b0, 5, 1'b0);
        idle_cycle();
        reset_mid_op();

`ifdef MULTDIV_TIMEOUT_EN
        run_op(1'b0, 32'd3, 32'd4, 5'd12, 1000, 1'b0, -1, 1'b0);
        idle_cycle();
`else
        run_op(1'b0, 32'd3, 32'd4, 5'd12, 1000, 1'b0, 100, 1'b0);
        idle_cycle();
`endif

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) idle_cycle();
            is_div = 1'($urandom_range(0, 1));
            a      = $urandom;
            b      = $urandom;
            if (is_div && $urandom_range(0, 7) == 0) b = 32'd0;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            rdy_at   = $urandom_range(2, 20);
            flush_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, rdy_at + 1) : -1;
            run_op(is_div, a, b, 5'($urandom), rdy_at, 1'($urandom_range(0, 5) == 0),
                   flush_at, 1'($urandom_range(0, 1)));
        end
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
